// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    localparam logic [3:0] SEG7_BLANK_CODE = 4'd8;
    localparam logic [6:0] SEG7_DARK       = 7'b0000000;

endpackage

// File: rtl/seg7.sv
// Seven-segment decoder for digit codes 0..7; codes 8..15 decode to blank.
// Output bit 6 = segment g ... bit 0 = segment a, active high.
module seg7 (
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (code_i)
            4'd0:    seg_o = 7'b0111111;
            4'd1:    seg_o = 7'b0000110;
            4'd2:    seg_o = 7'b1011011;
            4'd3:    seg_o = 7'b1001111;
            4'd4:    seg_o = 7'b1100110;
            4'd5:    seg_o = 7'b1101101;
            4'd6:    seg_o = 7'b1111101;
            4'd7:    seg_o = 7'b0000111;
            default: seg_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed display scanner with a shadow/active digit bank committed at frame ends.
// Optional macro SEG7_SCAN_BLANK_GAP_EN inserts one dark cycle between consecutive digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DWELL_W-1:0]            dwell,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [3:0]                    wr_value,
    output logic [6:0]                    segments,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]      cnt_q, cnt_d;
    logic [3:0]              shadow_q [NUM_DIGITS];
    logic [3:0]              shadow_d [NUM_DIGITS];
    logic [3:0]              active_q [NUM_DIGITS];
    logic [3:0]              active_d [NUM_DIGITS];
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    done_q, done_d;

    logic [6:0]              decoded;
    logic                    digitEnd;
    logic                    commitCycle;
    logic                    wrFire;

    seg7 u_seg7 (
        .code_i (active_q[idx_q]),
        .seg_o  (decoded)
    );

    // The >= compare lets a lowered dwell end the current digit immediately.
    assign digitEnd    = (state_q == SHOW) && (cnt_q >= dwell);
    assign commitCycle = digitEnd && (idx_q == LAST_IDX);
    assign wr_ready    = !rst && !commitCycle;
    assign wrFire      = wr_valid && wr_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        seg_d    = SEG7_DARK;
        sel_d    = '0;
        done_d   = 1'b0;

        if (wrFire && (32'(wr_digit) < NUM_DIGITS)) begin
            shadow_d[wr_digit] = wr_value;
        end

        // Outputs follow the current state one cycle later; a falling enable darkens them at once.
        if ((state_q == SHOW) && enable) begin
            seg_d = decoded;
            sel_d = NUM_DIGITS'(1) << idx_q;
        end

        case (state_q)
            IDLE: begin
                active_d = shadow_q;
                if (enable) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (digitEnd) begin
                    cnt_d = '0;
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    if (commitCycle) begin
                        active_d = shadow_q;
                        done_d   = 1'b1;
                    end
`ifdef SEG7_SCAN_BLANK_GAP_EN
                    state_d = GAP;
`else
                    state_d = SHOW;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = SHOW;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '{default: SEG7_BLANK_CODE};
            active_q <= '{default: SEG7_BLANK_CODE};
            seg_q    <= SEG7_DARK;
            sel_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
        end
    end

    assign segments   = seg_q;
    assign digit_sel  = sel_q;
    assign frame_done = done_q;

endmodule
